// File: rtl/audio_iir1_filter.sv
// First-order IIR audio filter (highpass RC model / lowpass), CHANNELS time-multiplexed streams, 2-stage pipeline.
// Optional output saturation and sticky sat flag: define IIR_SATURATE_EN (default build wraps, sat_flag_o tied 0).
module audio_iir1_filter #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     mode_i,
  input  logic [COEF_W-1:0]        alpha_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic [CH_W-1:0]          in_ch_i,
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic                     sat_flag_o
);

  localparam int DW = DATA_W + 2;
  localparam int PW = DW + COEF_W + 1;
  localparam int YW = DATA_W + 3;

  logic signed [DATA_W-1:0] xPrev_q [CHANNELS];
  logic signed [DATA_W-1:0] yPrev_q [CHANNELS];

  logic                     s1Valid_q, s1Valid_d;
  logic [CH_W-1:0]          s1Ch_q;
  logic                     s1Mode_q;
  logic [COEF_W-1:0]        s1Alpha_q;
  logic signed [DATA_W-1:0] s1X_q;
  logic signed [DATA_W-1:0] s1Yprev_q;
  logic signed [DW-1:0]     s1D_q;

  logic                     outValid_q;
  logic signed [DATA_W-1:0] outData_q;
  logic [CH_W-1:0]          outCh_q;

  logic                     chOk;
  logic                     accept;
  logic signed [DATA_W-1:0] xPrevRd;
  logic signed [DATA_W-1:0] yPrevRd;
  logic signed [DW-1:0]     dIn;

  logic signed [PW-1:0]     prod;
  logic signed [YW-1:0]     qW;
  logic signed [YW-1:0]     yWide;
  logic signed [DATA_W-1:0] yClip;
  logic                     satHit;

  // A sample for the channel sitting in S1 must wait until its state write lands.
  assign in_ready_o = en_i & ~clr_i & ~(s1Valid_q & (s1Ch_q == in_ch_i));
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    chOk    = (32'(in_ch_i) < 32'(CHANNELS));
    xPrevRd = '0;
    yPrevRd = '0;
    if (chOk) begin
      xPrevRd = xPrev_q[in_ch_i];
      yPrevRd = yPrev_q[in_ch_i];
    end
    if (mode_i) begin
      dIn = DW'(in_data_i) - DW'(yPrevRd);
    end else begin
      dIn = DW'(yPrevRd) + DW'(in_data_i) - DW'(xPrevRd);
    end
    s1Valid_d = accept & chOk;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      s1Ch_q    <= '0;
      s1Mode_q  <= 1'b0;
      s1Alpha_q <= '0;
      s1X_q     <= '0;
      s1Yprev_q <= '0;
      s1D_q     <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (s1Valid_d) begin
        s1Ch_q    <= in_ch_i;
        s1Mode_q  <= mode_i;
        s1Alpha_q <= alpha_i;
        s1X_q     <= in_data_i;
        s1Yprev_q <= yPrevRd;
        s1D_q     <= dIn;
      end
    end
  end

  // Alpha is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    prod  = PW'($signed({1'b0, s1Alpha_q})) * PW'(s1D_q);
    qW    = YW'(prod >>> COEF_W);
    yWide = s1Mode_q ? (YW'(s1Yprev_q) + qW) : qW;
  end

`ifdef IIR_SATURATE_EN
  localparam logic signed [YW-1:0] Y_MAX = YW'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

  logic satFlag_q;

  always_comb begin
    satHit = 1'b0;
    yClip  = DATA_W'(yWide);
    if (yWide > Y_MAX) begin
      satHit = 1'b1;
      yClip  = DATA_W'(Y_MAX);
    end else if (yWide < Y_MIN) begin
      satHit = 1'b1;
      yClip  = DATA_W'(Y_MIN);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      satFlag_q <= 1'b0;
    end else if (clr_i) begin
      satFlag_q <= 1'b0;
    end else if (s1Valid_q && satHit) begin
      satFlag_q <= 1'b1;
    end
  end

  assign sat_flag_o = satFlag_q;
`else
  always_comb begin
    satHit = 1'b0;
    yClip  = DATA_W'(yWide);
  end

  assign sat_flag_o = satHit;
`endif

  // clr wins over the S2 write so a clear issued mid-flight leaves clean state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        xPrev_q[i] <= '0;
        yPrev_q[i] <= '0;
      end
    end else if (clr_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        xPrev_q[i] <= '0;
        yPrev_q[i] <= '0;
      end
    end else if (s1Valid_q) begin
      xPrev_q[s1Ch_q] <= s1X_q;
      yPrev_q[s1Ch_q] <= yClip;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
    end else begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outData_q <= yClip;
        outCh_q   <= s1Ch_q;
      end
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign out_ch_o    = outCh_q;

endmodule

// File: tb/tb_audio_iir1_filter.sv
// Scoreboard bench for audio_iir1_filter: directed scenarios plus randomized traffic checked
// against an arithmetic model of the filter equations.
module tb_audio_iir1_filter;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;
  localparam longint Y_HI = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint Y_LO = -(64'sd1 <<< (DATA_W - 1));

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en = 1'b0;
  logic                     clr = 1'b0;
  logic                     mode = 1'b0;
  logic [COEF_W-1:0]        alpha = '0;
  logic                     inValid = 1'b0;
  logic                     inReady;
  logic signed [DATA_W-1:0] inData = '0;
  logic [CH_W-1:0]          inCh = '0;
  logic                     outValid;
  logic signed [DATA_W-1:0] outData;
  logic [CH_W-1:0]          outCh;
  logic                     satFlag;

  audio_iir1_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .CHANNELS(CHANNELS), .CH_W(CH_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mode_i(mode), .alpha_i(alpha),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData), .in_ch_i(inCh),
    .out_valid_o(outValid), .out_data_o(outData), .out_ch_o(outCh), .sat_flag_o(satFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int y;
    int ch;
    bit sat;
  } expItem_t;

  expItem_t expQ[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  mX[CHANNELS];
  int  mY[CHANNELS];
  bit  mSat = 1'b0;
  bit  lastValid = 1'b0;
  int  lastCh = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < CHANNELS; i++) begin
      mX[i] = 0;
      mY[i] = 0;
    end
    mSat = 1'b0;
  endfunction

  // y[n] from the difference equations, floor division by 2^COEF_W, then clamp or wrap.
  function automatic int modelStep(input int ch, input int x, input bit lp, input int a);
    longint d;
    longint q;
    longint yw;
    if (lp) d = longint'(x) - mY[ch];
    else    d = longint'(mY[ch]) + x - mX[ch];
    q  = (longint'(a) * d) >>> COEF_W;
    yw = lp ? mY[ch] + q : q;
`ifdef IIR_SATURATE_EN
    if (yw > Y_HI) begin
      yw = Y_HI;
      mSat = 1'b1;
    end else if (yw < Y_LO) begin
      yw = Y_LO;
      mSat = 1'b1;
    end
`else
    yw = yw & ((64'sd1 <<< DATA_W) - 1);
    if (yw > Y_HI) yw = yw - (64'sd1 <<< DATA_W);
`endif
    mX[ch] = x;
    mY[ch] = int'(yw);
    return int'(yw);
  endfunction

  // One cycle of stimulus; the expected handshake decides acceptance and feeds the scoreboard.
  task automatic applyStimulus(input bit v, input int ch, input int x, input bit lp, input int a,
                               input bit e, input bit c, output bit acc);
    bit expReady;
    int y;
    @(posedge clk);
    #1;
    inValid = v;
    inCh    = CH_W'(ch);
    inData  = DATA_W'(x);
    mode    = lp;
    alpha   = COEF_W'(a);
    en      = e;
    clr     = c;
    @(negedge clk);
    expReady = e && !c && !(lastValid && lastCh == ch);
    checkOutput("in_ready", longint'(inReady), longint'(expReady));
    acc = v && expReady;
    if (c) modelClear();
    if (acc) begin
      y = modelStep(ch, x, lp, a);
      expQ.push_back('{due: cyc + 2, y: y, ch: ch, sat: mSat});
    end
    lastValid = acc;
    lastCh    = ch;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, acc);
  endtask

  task automatic sendSample(input int ch, input int x, input bit lp, input int a);
    bit acc;
    int tries = 0;
    do begin
      applyStimulus(1'b1, ch, x, lp, a, 1'b1, 1'b0, acc);
      tries++;
    end while (!acc && tries < 4);
    if (!acc) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic clrPulse();
    bit acc;
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, acc);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    inValid = 1'b0;
    expQ.delete();
    modelClear();
    lastValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", longint'(outValid), 0);
    checkOutput("rst_out_data", longint'(outData), 0);
    checkOutput("rst_out_ch", longint'(outCh), 0);
    checkOutput("rst_sat_flag", longint'(satFlag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every presented result is matched against the oldest expected one.
  always @(negedge clk) begin
    expItem_t it;
    if (!rst) begin
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 1, 0);
        end else begin
          it = expQ.pop_front();
          checkOutput("out_data", longint'(outData), longint'(it.y));
          checkOutput("out_ch", longint'(outCh), longint'(it.ch));
          checkOutput("out_latency", longint'(cyc), longint'(it.due));
          checkOutput("sat_flag", longint'(satFlag), longint'(it.sat));
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        checkOutput("missing_out_valid", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    modelClear();
    doReset();

    // HP step on ch0: 500, 250, 125
    for (int i = 0; i < 3; i++) sendSample(0, 1000, 1'b0, 32'h8000);
    idle(3);

    // clear, then a fresh HP step must restart at 500 and sat_flag reads 0
    clrPulse();
    checkOutput("sat_after_clr", longint'(satFlag), 0);
    sendSample(0, 1000, 1'b0, 32'h8000);
    idle(3);

    // LP step on ch1: 500, 750, 875; ch0 then sees only its own history
    clrPulse();
    for (int i = 0; i < 3; i++) sendSample(1, 1000, 1'b1, 32'h8000);
    sendSample(0, 0, 1'b0, 32'h8000);
    idle(3);

    // interleaved channels at full rate, then a same-channel back-to-back stall
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i % 2, 100 * i - 300, i[1], 32'h4000, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 0, 700, 1'b0, 32'h8000, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 0, 800, 1'b0, 32'h8000, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 0, 800, 1'b0, 32'h8000, 1'b1, 1'b0, acc);
    idle(3);

    // near-full-scale HP: 0, 32766, then the out-of-range result
    clrPulse();
    sendSample(0, 0, 1'b0, 32'hFFFF);
    sendSample(0, 32767, 1'b0, 32'hFFFF);
    sendSample(0, -32768, 1'b0, 32'hFFFF);
    idle(3);
    checkOutput("sat_sticky", longint'(satFlag), longint'(mSat));
    clrPulse();
    checkOutput("sat_cleared", longint'(satFlag), 0);

    // clr while a sample is in S1: result still emitted, its state write dropped
    sendSample(0, 1000, 1'b0, 32'h8000);
    clrPulse();
    sendSample(0, 1000, 1'b0, 32'h8000);
    idle(3);

    // alpha = 0: HP gives 0, LP holds its previous output
    sendSample(1, 1234, 1'b1, 32'h8000);
    sendSample(1, -500, 1'b1, 0);
    sendSample(0, 4321, 1'b0, 0);
    idle(3);

    // en low: nothing new accepted while the pipeline drains
    sendSample(1, 2000, 1'b0, 32'h6000);
    applyStimulus(1'b1, 0, 555, 1'b0, 32'h6000, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 0, 555, 1'b0, 32'h6000, 1'b0, 1'b0, acc);
    idle(3);

    // reset with two samples in flight, then a fresh HP step gives 500
    sendSample(0, 3000, 1'b0, 32'h8000);
    sendSample(1, 3000, 1'b1, 32'h8000);
    doReset();
    sendSample(0, 1000, 1'b0, 32'h8000);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit lp;
      bit e;
      int ch;
      int x;
      int a;
      v  = ($urandom_range(0, 3) != 0);
      ch = int'($urandom_range(0, CHANNELS - 1));
      lp = bit'($urandom_range(0, 1));
      e  = ($urandom_range(0, 9) != 0);
      a  = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else x = int'($urandom_range(0, 4000)) - 2000;
      applyStimulus(v, ch, x, lp, a, e, 1'b0, acc);
    end
    idle(4);

    if (expQ.size() != 0) checkOutput("leftover_expected", longint'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
